// File: rtl/ball_motion_ctrl_pkg.sv
// rtl/ball_motion_ctrl_pkg.sv - shared types and maze geometry defaults for ball motion
package ball_motion_ctrl_pkg;

  // Geometry defaults shared with the maze render/collision logic
  localparam logic [4:0]  DEF_BALL_W  = 5'd10;
  localparam logic [10:0] DEF_START_X = 11'd40;
  localparam logic [10:0] DEF_START_Y = 11'd40;
  localparam logic [10:0] DEF_H_MAX   = 11'd640;
  localparam logic [10:0] DEF_V_MAX   = 11'd480;
  localparam logic [10:0] DEF_GOAL_X0 = 11'd580;
  localparam logic [10:0] DEF_GOAL_X1 = 11'd620;
  localparam logic [10:0] DEF_GOAL_Y0 = 11'd460;
  localparam logic [10:0] DEF_GOAL_Y1 = 11'd470;

  // Per-frame sequencer states; each step walks SETTLE_X..MOVE_Y once
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE_X = 3'd1,
    ST_MOVE_X   = 3'd2,
    ST_SETTLE_Y = 3'd3,
    ST_MOVE_Y   = 3'd4,
    ST_GOAL     = 3'd5
  } state_e;

  // Direction of travel along one axis
  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_POS  = 2'b01,
    DIR_NEG  = 2'b10
  } dir_e;

  // Opposing requests cancel out
  function automatic dir_e decode_dir(input logic pos_req, input logic neg_req);
    if (pos_req && !neg_req) return DIR_POS;
    if (neg_req && !pos_req) return DIR_NEG;
    return DIR_NONE;
  endfunction

endpackage

// File: rtl/ball_axis_step.sv
// rtl/ball_axis_step.sv - single-axis one-pixel step candidate with wall/clamp blocking
module ball_axis_step
  import ball_motion_ctrl_pkg::*;
(
  input  logic [10:0] pos,
  input  dir_e        dir,
  input  logic        stop_pos,
  input  logic        stop_neg,
  input  logic [10:0] limit,
  output logic [10:0] next_pos,
  output logic        blocked
);

  // Candidate position plus a block flag; the clamp test precedes the add so nothing wraps
  always_comb begin
    next_pos = pos;
    blocked  = 1'b1;
    case (dir)
      DIR_POS: begin
        next_pos = pos + 11'd1;
        blocked  = stop_pos || (pos >= limit);
      end
      DIR_NEG: begin
        next_pos = pos - 11'd1;
        blocked  = stop_neg || (pos == 11'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// rtl/ball_motion_ctrl.sv - per-frame ball stepping with collision sampling, clamping and goal re-spawn
module ball_motion_ctrl
  import ball_motion_ctrl_pkg::*;
#(
  parameter logic [4:0]  BALL_W  = DEF_BALL_W,
  parameter logic [10:0] START_X = DEF_START_X,
  parameter logic [10:0] START_Y = DEF_START_Y,
  parameter logic [10:0] H_MAX   = DEF_H_MAX,
  parameter logic [10:0] V_MAX   = DEF_V_MAX,
  parameter logic [10:0] GOAL_X0 = DEF_GOAL_X0,
  parameter logic [10:0] GOAL_X1 = DEF_GOAL_X1,
  parameter logic [10:0] GOAL_Y0 = DEF_GOAL_Y0,
  parameter logic [10:0] GOAL_Y1 = DEF_GOAL_Y1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        req_right,
  input  logic        req_left,
  input  logic        req_up,
  input  logic        req_down,
  input  logic [2:0]  speed,
  input  logic        stop_right,
  input  logic        stop_left,
  input  logic        stop_up,
  input  logic        stop_down,
  output logic [10:0] x_ball,
  output logic [10:0] y_ball,
  output logic [4:0]  ball_width,
  output logic        busy,
  output logic        win,
  output logic        overrun
);

  localparam logic [10:0] X_LIMIT = H_MAX - {6'd0, BALL_W};
  localparam logic [10:0] Y_LIMIT = V_MAX - {6'd0, BALL_W};

  state_e      state_q, state_d;
  logic [10:0] x_q, y_q;
  logic [10:0] x_next, y_next;
  logic        x_blocked, y_blocked;
  dir_e        h_dir_q, v_dir_q;
  dir_e        h_req, v_req;
  logic [2:0]  steps_q;
  logic        start_ok;
  logic        at_goal;

  assign h_req      = decode_dir(req_right, req_left);
  assign v_req      = decode_dir(req_down, req_up);
  assign start_ok   = (speed != 3'd0) && ((h_req != DIR_NONE) || (v_req != DIR_NONE));
  assign at_goal    = (x_q >= GOAL_X0) && (x_q <= GOAL_X1) && (y_q >= GOAL_Y0) && (y_q <= GOAL_Y1);
  assign x_ball     = x_q;
  assign y_ball     = y_q;
  assign ball_width = BALL_W;

  ball_axis_step u_x_step (
    .pos      (x_q),
    .dir      (h_dir_q),
    .stop_pos (stop_right),
    .stop_neg (stop_left),
    .limit    (X_LIMIT),
    .next_pos (x_next),
    .blocked  (x_blocked)
  );

  ball_axis_step u_y_step (
    .pos      (y_q),
    .dir      (v_dir_q),
    .stop_pos (stop_down),
    .stop_neg (stop_up),
    .limit    (Y_LIMIT),
    .next_pos (y_next),
    .blocked  (y_blocked)
  );

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and status pulses; a tick arriving mid-frame only raises overrun
  always_comb begin
    state_d = state_q;
    busy    = (state_q != ST_IDLE);
    win     = 1'b0;
    overrun = frame_tick && (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE:     if (frame_tick && start_ok) state_d = ST_SETTLE_X;
      ST_SETTLE_X: state_d = ST_MOVE_X;
      ST_MOVE_X:   state_d = ST_SETTLE_Y;
      ST_SETTLE_Y: state_d = ST_MOVE_Y;
      ST_MOVE_Y:   state_d = (steps_q > 3'd1) ? ST_SETTLE_X : ST_GOAL;
      ST_GOAL: begin
        win     = at_goal;
        state_d = ST_IDLE;
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  // Request latch, per-axis stepping, step counting and goal re-spawn
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= START_X;
      y_q     <= START_Y;
      h_dir_q <= DIR_NONE;
      v_dir_q <= DIR_NONE;
      steps_q <= 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frame_tick) begin
            h_dir_q <= h_req;
            v_dir_q <= v_req;
            steps_q <= speed;
          end
        end
        ST_MOVE_X: if (!x_blocked) x_q <= x_next;
        ST_MOVE_Y: begin
          if (!y_blocked) y_q <= y_next;
          steps_q <= steps_q - 3'd1;
        end
        ST_GOAL: begin
          if (at_goal) begin
            x_q <= START_X;
            y_q <= START_Y;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb/tb_ball_motion_ctrl.sv - self-checking bench for ball_motion_ctrl
module tb_ball_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        req_right = 1'b0, req_left = 1'b0, req_up = 1'b0, req_down = 1'b0;
  logic [2:0]  speed = 3'd0;
  logic        stop_right = 1'b0, stop_left = 1'b0, stop_up = 1'b0, stop_down = 1'b0;
  logic [10:0] x_ball, y_ball;
  logic [4:0]  ball_width;
  logic        busy, win, overrun;

  ball_motion_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .req_right  (req_right),
    .req_left   (req_left),
    .req_up     (req_up),
    .req_down   (req_down),
    .speed      (speed),
    .stop_right (stop_right),
    .stop_left  (stop_left),
    .stop_up    (stop_up),
    .stop_down  (stop_down),
    .x_ball     (x_ball),
    .y_ball     (y_ball),
    .ball_width (ball_width),
    .busy       (busy),
    .win        (win),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference ball position and per-frame expectations
  int mx = 40, my = 40;
  int exp_busy, exp_win, exp_wx, exp_wy;
  // Observations of the last frame
  int x_hist [0:127];
  int y_hist [0:127];
  int obs_busy, obs_wins, obs_wx, obs_wy;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Frame model: walk pixel by pixel, x then y, honouring walls and the screen edges
  task automatic model_frame(input logic r, l, u, d, input int spd, input logic sr, sl, su, sd);
    int hd, vd;
    hd = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
    vd = (d && !u) ? 1 : ((u && !d) ? -1 : 0);
    exp_win = 0;
    if (spd == 0 || (hd == 0 && vd == 0)) begin
      exp_busy = 0;
      return;
    end
    exp_busy = 4 * spd + 1;
    for (int k = 0; k < spd; k++) begin
      if (hd == 1 && !sr && mx + 1 <= 640 - 10) mx = mx + 1;
      if (hd == -1 && !sl && mx - 1 >= 0) mx = mx - 1;
      if (vd == 1 && !sd && my + 1 <= 480 - 10) my = my + 1;
      if (vd == -1 && !su && my - 1 >= 0) my = my - 1;
    end
    if (mx >= 580 && mx <= 620 && my >= 460 && my <= 470) begin
      exp_win = 1;
      exp_wx = mx;
      exp_wy = my;
      mx = 40;
      my = 40;
    end
  endtask

  // Issue one tick at a negedge and observe the frame until busy falls (bounded)
  task automatic drive_frame(input logic r, l, u, d, input int spd, input logic sr, sl, su, sd);
    int k;
    req_right = r; req_left = l; req_up = u; req_down = d;
    speed = spd[2:0];
    stop_right = sr; stop_left = sl; stop_up = su; stop_down = sd;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    k = 0;
    obs_wins = 0;
    obs_wx = -1;
    obs_wy = -1;
    while (busy && k < 120) begin
      x_hist[k] = int'(x_ball);
      y_hist[k] = int'(y_ball);
      if (win) begin
        obs_wins++;
        obs_wx = int'(x_ball);
        obs_wy = int'(y_ball);
      end
      k++;
      @(negedge clk);
    end
    obs_busy = k;
    check("frame_bounded", (k < 120), 1);
  endtask

  task automatic frame_check(input string tag, input logic r, l, u, d, input int spd,
                             input logic sr, sl, su, sd);
    model_frame(r, l, u, d, spd, sr, sl, su, sd);
    drive_frame(r, l, u, d, spd, sr, sl, su, sd);
    check({tag, "_busy_cycles"}, obs_busy, exp_busy);
    check({tag, "_win_count"}, obs_wins, exp_win);
    if (exp_win == 1) begin
      check({tag, "_win_x"}, obs_wx, exp_wx);
      check({tag, "_win_y"}, obs_wy, exp_wy);
    end
    check({tag, "_x"}, x_ball, mx);
    check({tag, "_y"}, y_ball, my);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    frame_tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mx = 40;
    my = 40;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int bound;
    // 1. Reset hold
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_x", x_ball, 40);
    check("reset_y", y_ball, 40);
    check("reset_busy", busy, 0);
    check("reset_win", win, 0);
    check("reset_overrun", overrun, 0);
    check("ball_width", ball_width, 10);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_x", x_ball, 40);
    check("idle_y", y_ball, 40);
    check("idle_busy", busy, 0);

    // 2. Free diagonal move, with step latency
    frame_check("free", 1, 0, 0, 1, 3, 0, 0, 0, 0);
    check("free_x_abs", x_ball, 43);
    check("free_busy_abs", obs_busy, 13);
    check("lat_x_edge1", x_hist[1], 40);
    check("lat_x_edge2", x_hist[2], 41);
    check("lat_y_edge3", y_hist[3], 40);
    check("lat_y_edge4", y_hist[4], 41);

    // Degenerate requests: no motion, never busy
    frame_check("speed0", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    frame_check("both_lr", 1, 1, 0, 0, 5, 0, 0, 0, 0);

    // 3. Wall on the right, then slide down
    do_reset();
    frame_check("wall_r", 1, 0, 0, 0, 5, 1, 0, 0, 0);
    check("wall_r_abs", x_ball, 40);
    frame_check("wall_down", 0, 0, 0, 1, 5, 1, 0, 0, 0);
    check("wall_down_abs", y_ball, 45);
    frame_check("slide", 1, 0, 0, 1, 4, 0, 0, 0, 1);
    frame_check("both_stop", 1, 0, 1, 0, 6, 1, 0, 1, 0);

    // 4. Clamp at left and bottom edges
    do_reset();
    bound = 0;
    while (mx > 0 && bound < 20) begin
      frame_check("to_left", 0, 1, 0, 0, 7, 0, 0, 0, 0);
      bound++;
    end
    frame_check("clamp_left", 0, 1, 0, 0, 7, 0, 0, 0, 0);
    check("clamp_left_abs", x_ball, 0);
    bound = 0;
    while (my < 470 && bound < 80) begin
      frame_check("to_bottom", 0, 0, 0, 1, 7, 0, 0, 0, 0);
      bound++;
    end
    frame_check("clamp_bottom", 0, 0, 0, 1, 7, 0, 0, 0, 0);
    check("clamp_bottom_abs", y_ball, 470);

    // 5. Goal: approach (590,455) outside the window, then enter it
    do_reset();
    bound = 0;
    while (mx < 590 && bound < 100) begin
      n = (590 - mx > 7) ? 7 : 590 - mx;
      frame_check("to_goal_x", 1, 0, 0, 0, n, 0, 0, 0, 0);
      bound++;
    end
    bound = 0;
    while (my < 455 && bound < 100) begin
      n = (455 - my > 7) ? 7 : 455 - my;
      frame_check("to_goal_y", 0, 0, 0, 1, n, 0, 0, 0, 0);
      bound++;
    end
    frame_check("goal", 0, 0, 0, 1, 7, 0, 0, 0, 0);
    check("goal_pulse", obs_wins, 1);
    check("goal_win_y", obs_wy, 462);
    check("goal_respawn_x", x_ball, 40);
    check("goal_respawn_y", y_ball, 40);

    // 6a. Tick while busy: overrun pulse, motion unaffected
    model_frame(1, 0, 0, 1, 4, 0, 0, 0, 0);
    req_right = 1; req_left = 0; req_up = 0; req_down = 1; speed = 3'd4;
    stop_right = 0; stop_left = 0; stop_up = 0; stop_down = 0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    req_right = 0; req_left = 1; req_up = 1; req_down = 0; speed = 3'd7;
    frame_tick = 1'b1;
    #1;
    check("overrun_high", overrun, 1);
    @(negedge clk);
    frame_tick = 1'b0;
    #1;
    check("overrun_low", overrun, 0);
    bound = 0;
    while (busy && bound < 100) begin
      @(negedge clk);
      bound++;
    end
    check("overrun_bounded", (bound < 100), 1);
    check("overrun_x", x_ball, mx);
    check("overrun_y", y_ball, my);

    // 6b. Reset mid-frame discards pending steps
    req_right = 1; req_left = 0; req_up = 0; req_down = 1; speed = 3'd7;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_x", x_ball, 40);
    check("midrst_y", y_ball, 40);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mx = 40;
    my = 40;
    repeat (40) @(negedge clk);
    check("midrst_hold_x", x_ball, 40);
    check("midrst_hold_y", y_ball, 40);

    // 7. Randomised frames against the model
    for (int i = 0; i < 60; i++) begin
      logic r, l, u, d, sr, sl, su, sd;
      r = ($urandom_range(0, 2) != 0);
      l = ($urandom_range(0, 3) == 0);
      u = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 2) != 0);
      sr = ($urandom_range(0, 3) == 0);
      sl = ($urandom_range(0, 3) == 0);
      su = ($urandom_range(0, 3) == 0);
      sd = ($urandom_range(0, 3) == 0);
      frame_check("rand", r, l, u, d, int'($urandom_range(0, 7)), sr, sl, su, sd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
